// File: rtl/rx_serial_pkg.sv
// Shared definitions for the 7O1 serial receiver: FSM state codes,
// frame geometry and the default bit period.
`timescale 1ns/1ps
package rx_serial_pkg;

  localparam int DATA_BITS            = 7;
  localparam int CLKS_PER_BIT_DEFAULT = 434;

  // State codes, also exported on db_estado.
  localparam logic [3:0] ST_INICIAL     = 4'd0;
  localparam logic [3:0] ST_START       = 4'd1;
  localparam logic [3:0] ST_DADOS       = 4'd2;
  localparam logic [3:0] ST_PARIDADE    = 4'd3;
  localparam logic [3:0] ST_STOP        = 4'd4;
  localparam logic [3:0] ST_FINAL       = 4'd5;
  localparam logic [3:0] ST_ESPERA_IDLE = 4'd6;

  // Odd parity holds when data bits plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data,
                                         input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/rx_serial_7o1_if.sv
// Serial line, consumer handshake and result bus of the 7O1 receiver.
// Handshake: tem_dado rises together with the one-cycle pronto pulse and stays
// high until the consumer drives recebe=1 for a cycle; a FINAL in that same
// cycle keeps tem_dado set. overrun exists only with RX_SERIAL_OVERRUN_EN.
`timescale 1ns/1ps
interface rx_serial_7o1_if;
  import rx_serial_pkg::*;

  logic                 dado_serial;
  logic                 recebe;
  logic [DATA_BITS-1:0] dados_ascii;
  logic                 paridade_ok;
  logic                 erro_frame;
  logic                 pronto;
  logic                 tem_dado;
  logic [3:0]           db_estado;
`ifdef RX_SERIAL_OVERRUN_EN
  logic                 overrun;
`endif

  // Receiver side.
  modport slave (
    input  dado_serial, recebe,
    output dados_ascii, paridade_ok, erro_frame, pronto, tem_dado, db_estado
`ifdef RX_SERIAL_OVERRUN_EN
    , output overrun
`endif
  );

  // Line driver / consumer side.
  modport master (
    output dado_serial, recebe,
    input  dados_ascii, paridade_ok, erro_frame, pronto, tem_dado, db_estado
`ifdef RX_SERIAL_OVERRUN_EN
    , input overrun
`endif
  );

endinterface

// File: rtl/rx_baud_counter.sv
// Loadable bit-period down-counter. load (with half) sets the first period
// to a half bit, otherwise a full bit; while enabled it reloads itself on
// reaching zero and raises tick for that cycle.
`timescale 1ns/1ps
module rx_baud_counter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic half_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1 = 16'((CLKS_PER_BIT / 2) - 1);

  logic [15:0] cnt_q, cnt_d;

  // Next count: load has priority, then enabled count-down with auto reload.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = half_i ? HALF_M1 : FULL_M1;
    end else if (enable_i) begin
      cnt_d = (cnt_q == 16'd0) ? FULL_M1 : cnt_q - 16'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= 16'd0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = enable_i & (cnt_q == 16'd0);

endmodule

// File: rtl/rx_serial_7o1.sv
// 7O1 asynchronous serial receiver: start, 7 data bits LSB first, odd
// parity, stop. Line is synchronised, sampled mid-bit, and the result is
// published in FINAL with a pronto pulse and a sticky tem_dado flag.
// Optional overrun flag: define RX_SERIAL_OVERRUN_EN.
`timescale 1ns/1ps
module rx_serial_7o1
  import rx_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic            clock,
  input  logic            reset,
  rx_serial_7o1_if.slave  bus
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   line;

  logic [3:0]           state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 par_q, par_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] dados_q, dados_d;
  logic                 par_ok_q, par_ok_d;
  logic                 erro_q, erro_d;
  logic                 pronto_q, pronto_d;
  logic                 tem_q, tem_d;
`ifdef RX_SERIAL_OVERRUN_EN
  logic                 ovr_q, ovr_d;
`endif

  logic cnt_load, cnt_half, cnt_en, tick;

  assign line = sync_q[SYNC_STAGES-1];

  // Synchroniser and previous-sample flop for falling-edge detection; idle-high on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.dado_serial};
      prev_q <= line;
    end
  end

  rx_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_i    (clock),
    .rst_ni   (reset),
    .load_i   (cnt_load),
    .half_i   (cnt_half),
    .enable_i (cnt_en),
    .tick_o   (tick)
  );

  // FSM next state, datapath updates and bit-timer control.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    stop_d    = stop_q;
    dados_d   = dados_q;
    par_ok_d  = par_ok_q;
    erro_d    = erro_q;
    pronto_d  = 1'b0;
    tem_d     = tem_q;
`ifdef RX_SERIAL_OVERRUN_EN
    ovr_d     = ovr_q;
`endif
    cnt_load  = 1'b0;
    cnt_half  = 1'b0;
    cnt_en    = 1'b0;

    // Consumer acknowledge; a FINAL below overrides it.
    if (bus.recebe) begin
      tem_d = 1'b0;
`ifdef RX_SERIAL_OVERRUN_EN
      ovr_d = 1'b0;
`endif
    end

    case (state_q)
      ST_INICIAL: begin
        if (prev_q && !line) begin
          cnt_load = 1'b1;
          cnt_half = 1'b1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        cnt_en = 1'b1;
        if (tick) begin
          if (!line) begin
            cnt_load  = 1'b1;
            bit_cnt_d = 3'd0;
            state_d   = ST_DADOS;
          end else begin
            state_d = ST_INICIAL;
          end
        end
      end
      ST_DADOS: begin
        cnt_en = 1'b1;
        if (tick) begin
          shift_d   = {line, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = ST_PARIDADE;
        end
      end
      ST_PARIDADE: begin
        cnt_en = 1'b1;
        if (tick) begin
          par_d   = line;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        cnt_en = 1'b1;
        if (tick) begin
          stop_d  = line;
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        dados_d  = shift_q;
        par_ok_d = odd_parity_ok(shift_q, par_q);
        erro_d   = ~stop_q;
        pronto_d = 1'b1;
        tem_d    = 1'b1;
`ifdef RX_SERIAL_OVERRUN_EN
        if (tem_q && !bus.recebe) ovr_d = 1'b1;
`endif
        if (stop_q) begin
          state_d = ST_INICIAL;
        end else begin
          cnt_load = 1'b1;
          state_d  = ST_ESPERA_IDLE;
        end
      end
      ST_ESPERA_IDLE: begin
        // Any low sample restarts the one-bit idle window.
        if (!line) begin
          cnt_load = 1'b1;
        end else begin
          cnt_en = 1'b1;
          if (tick) state_d = ST_INICIAL;
        end
      end
      default: state_d = ST_INICIAL;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_INICIAL;
      shift_q   <= '0;
      bit_cnt_q <= 3'd0;
      par_q     <= 1'b0;
      stop_q    <= 1'b0;
      dados_q   <= '0;
      par_ok_q  <= 1'b0;
      erro_q    <= 1'b0;
      pronto_q  <= 1'b0;
      tem_q     <= 1'b0;
`ifdef RX_SERIAL_OVERRUN_EN
      ovr_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      stop_q    <= stop_d;
      dados_q   <= dados_d;
      par_ok_q  <= par_ok_d;
      erro_q    <= erro_d;
      pronto_q  <= pronto_d;
      tem_q     <= tem_d;
`ifdef RX_SERIAL_OVERRUN_EN
      ovr_q     <= ovr_d;
`endif
    end
  end

  assign bus.dados_ascii = dados_q;
  assign bus.paridade_ok = par_ok_q;
  assign bus.erro_frame  = erro_q;
  assign bus.pronto      = pronto_q;
  assign bus.tem_dado    = tem_q;
  assign bus.db_estado   = state_q;
`ifdef RX_SERIAL_OVERRUN_EN
  assign bus.overrun     = ovr_q;
`endif

endmodule

// File: tb/tb_rx_serial_7o1.sv
// Bench for rx_serial_7o1: directed 7O1 frames, glitch, break, handshake and
// mid-frame reset, with a frame-level model checked on every pronto.
`timescale 1ns/1ps
module tb_rx_serial_7o1;
  import rx_serial_pkg::*;

  localparam int CPB  = 434;
  localparam int SYNC = 2;
  localparam int EXP_LAT = (19 * CPB) / 2 + SYNC + 1;

  // Clock and reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  rx_serial_7o1_if bus();

  rx_serial_7o1 #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int start_cyc = 0;
  logic [8:0] exp_q[$];   // {data[6:0], paridade_ok, erro_frame}
  logic pronto_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: result fields from the bits put on the line.
  function automatic logic [8:0] model_frame(input logic [6:0] d, input logic p, input logic s);
    logic ok;
    ok = (($countones({d, p}) % 2) == 1);
    return {d, ok, ~s};
  endfunction

  // Driver tasks
  task automatic drive_bit(input logic b);
    bus.dado_serial = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Line is left at the stop value afterwards.
  task automatic send_frame(input logic [6:0] d, input logic p, input logic s, input bit expect_it);
    @(negedge clk);
    if (expect_it) exp_q.push_back(model_frame(d, p, s));
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 7; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_recebe();
    @(negedge clk);
    bus.recebe = 1'b1;
    @(negedge clk);
    bus.recebe = 1'b0;
  endtask

  // Scoreboard: every pronto must match the oldest expected frame.
  always @(negedge clk) begin
    logic [8:0] e;
    int lat;
    if (rst_n && bus.pronto) begin
      chk("pronto_width", {31'd0, pronto_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_pronto: got pronto=1 with data 0x%0h, want no pronto", bus.dados_ascii);
      end else begin
        e = exp_q.pop_front();
        chk("dados_ascii", {25'd0, bus.dados_ascii}, {25'd0, e[8:2]});
        chk("paridade_ok", {31'd0, bus.paridade_ok}, {31'd0, e[1]});
        chk("erro_frame",  {31'd0, bus.erro_frame},  {31'd0, e[0]});
        chk("tem_dado_at_pronto", {31'd0, bus.tem_dado}, 32'd1);
        lat = cyc - start_cyc;
        n_vec++;
        if (lat < EXP_LAT - 4 || lat > EXP_LAT + 4) begin
          n_bad++;
          $display("FAIL latency: got %0d cycles, want %0d +/- 4", lat, EXP_LAT);
        end
      end
    end
    pronto_prev = bus.pronto;
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dados"},  {25'd0, bus.dados_ascii}, 32'd0);
    chk({tag, "_parok"},  {31'd0, bus.paridade_ok}, 32'd0);
    chk({tag, "_erro"},   {31'd0, bus.erro_frame},  32'd0);
    chk({tag, "_pronto"}, {31'd0, bus.pronto},      32'd0);
    chk({tag, "_tem"},    {31'd0, bus.tem_dado},    32'd0);
    chk({tag, "_estado"}, {28'd0, bus.db_estado},   32'd0);
`ifdef RX_SERIAL_OVERRUN_EN
    chk({tag, "_overrun"}, {31'd0, bus.overrun},    32'd0);
`endif
  endtask

  initial begin
    bit hit;
    bus.dado_serial = 1'b1;
    bus.recebe      = 1'b0;
    rst_n           = 1'b0;
    idle(5);
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle(20);

    // Normal frames
    send_frame(7'h35, 1'b1, 1'b1, 1'b1);
    idle(200);
    chk("lit_35_data",  {25'd0, bus.dados_ascii}, 32'h35);
    chk("lit_35_parok", {31'd0, bus.paridade_ok}, 32'd1);
    chk("lit_35_erro",  {31'd0, bus.erro_frame},  32'd0);
    chk("lit_35_tem",   {31'd0, bus.tem_dado},    32'd1);
    send_frame(7'h55, 1'b1, 1'b1, 1'b1);
    idle(200);
    send_frame(7'h7E, 1'b1, 1'b1, 1'b1);
    idle(200);
    send_frame(7'h7F, 1'b0, 1'b1, 1'b1);
    idle(200);
    chk("lit_7f_data",  {25'd0, bus.dados_ascii}, 32'h7F);
    chk("lit_7f_parok", {31'd0, bus.paridade_ok}, 32'd1);

    // Parity error
    send_frame(7'h35, 1'b0, 1'b1, 1'b1);
    idle(200);
    chk("lit_perr_data",  {25'd0, bus.dados_ascii}, 32'h35);
    chk("lit_perr_parok", {31'd0, bus.paridade_ok}, 32'd0);

    // Acknowledge
    pulse_recebe();
    chk("recebe_clears_tem", {31'd0, bus.tem_dado}, 32'd0);

    // Glitch rejection
    @(negedge clk);
    bus.dado_serial = 1'b0;
    idle(50);
    chk("glitch_in_start", {28'd0, bus.db_estado}, {28'd0, ST_START});
    idle(50);
    bus.dado_serial = 1'b1;
    idle(300);
    chk("glitch_back_idle", {28'd0, bus.db_estado}, {28'd0, ST_INICIAL});
    chk("glitch_no_tem",    {31'd0, bus.tem_dado},  32'd0);
    idle(1000);
    send_frame(7'h55, 1'b1, 1'b1, 1'b1);
    idle(200);

    // Framing error followed by a held-low break
    send_frame(7'h55, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      idle(1000);
      chk("break_espera", {28'd0, bus.db_estado}, {28'd0, ST_ESPERA_IDLE});
    end
    chk("lit_break_erro", {31'd0, bus.erro_frame}, 32'd1);
    bus.dado_serial = 1'b1;
    idle(CPB - 20);
    chk("recover_not_yet", {28'd0, bus.db_estado}, {28'd0, ST_ESPERA_IDLE});
    idle(30);
    chk("recover_idle", {28'd0, bus.db_estado}, {28'd0, ST_INICIAL});
    send_frame(7'h7E, 1'b1, 1'b1, 1'b1);
    idle(200);
    chk("lit_after_break_erro", {31'd0, bus.erro_frame}, 32'd0);

    // recebe in the FINAL cycle: set wins
    hit = 1'b0;
    fork
      send_frame(7'h35, 1'b1, 1'b1, 1'b1);
      begin
        for (int i = 0; i < 6000 && !hit; i++) begin
          @(negedge clk);
          if (bus.db_estado == ST_FINAL) hit = 1'b1;
        end
        if (hit) begin
          bus.recebe = 1'b1;
          @(posedge clk);
          #1 bus.recebe = 1'b0;
        end
      end
    join
    chk("final_seen", {31'd0, hit}, 32'd1);
    idle(200);
    chk("coincident_tem", {31'd0, bus.tem_dado}, 32'd1);
`ifdef RX_SERIAL_OVERRUN_EN
    chk("coincident_overrun", {31'd0, bus.overrun}, 32'd0);
    pulse_recebe();
    send_frame(7'h55, 1'b1, 1'b1, 1'b1);
    idle(200);
    chk("ovr_first", {31'd0, bus.overrun}, 32'd0);
    send_frame(7'h7F, 1'b0, 1'b1, 1'b1);
    idle(200);
    chk("ovr_set",  {31'd0, bus.overrun},      32'd1);
    chk("ovr_data", {25'd0, bus.dados_ascii},  32'h7F);
    pulse_recebe();
    chk("ovr_clr_tem", {31'd0, bus.tem_dado}, 32'd0);
    chk("ovr_clr",     {31'd0, bus.overrun},  32'd0);
    send_frame(7'h7E, 1'b1, 1'b1, 1'b1);
    idle(200);
`endif

    // Reset during data bit 3
    fork
      send_frame(7'h7F, 1'b0, 1'b1, 1'b0);
      begin
        idle(4 * CPB + CPB / 2);
        #5 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
      end
    join
    idle(20);
    rst_n = 1'b1;
    idle(200);
    chk("post_reset_idle", {28'd0, bus.db_estado}, {28'd0, ST_INICIAL});
    send_frame(7'h7F, 1'b0, 1'b1, 1'b1);
    idle(200);
    chk("lit_post_reset_data", {25'd0, bus.dados_ascii}, 32'h7F);
    chk("lit_post_reset_tem",  {31'd0, bus.tem_dado},    32'd1);

    idle(100);
    chk("pending_frames", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
